// File: rtl/id_ex_pipeline_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipeline_reg_if
// Description : Bundle of the decode-side fields entering the ID/EX pipeline
//               register and of the registered copies it presents to the
//               execute stage.
//               master : decode side, drives the inputs and observes Out_*
//               slave  : the pipeline register, reads inputs and drives Out_*
// Revision    : 1.0  initial release
// ============================================================================
interface id_ex_pipeline_reg_if;
    // decode-stage side
    logic        Write_Enable;
    logic        Memory_Access;
    logic        Mem_Write;
    logic        Mem_Read;
    logic        Jump_and_Link;
    logic        Immediate_Select;
    logic        Offset_Generate;
    logic        Branch;
    logic        Jump;
    logic [4:0]  ALU_Opcode;
    logic [31:0] PC;
    logic [31:0] PC_next;
    logic [31:0] Data1;
    logic [31:0] Data2;
    logic [31:0] instruction;
    logic [31:0] Immediate_value;

    // execute-stage side
    logic        Out_Write_Enable;
    logic        Out_Memory_Access;
    logic        Out_Mem_Write;
    logic        Out_Mem_Read;
    logic        Out_Jump_and_Link;
    logic        Out_Immediate_Select;
    logic        Out_Offset_Generate;
    logic        Out_Branch;
    logic        Out_Jump;
    logic [4:0]  Out_ALU_Opcode;
    logic [31:0] Out_PC;
    logic [31:0] Out_PC_next;
    logic [31:0] Out_Data1;
    logic [31:0] Out_Data2;
    logic [31:0] Out_Immediate_value;
    logic [4:0]  Out_WriteAddress;
    logic [2:0]  Out_func3;

    modport master (
        output Write_Enable, Memory_Access, Mem_Write, Mem_Read, Jump_and_Link,
               Immediate_Select, Offset_Generate, Branch, Jump, ALU_Opcode,
               PC, PC_next, Data1, Data2, instruction, Immediate_value,
        input  Out_Write_Enable, Out_Memory_Access, Out_Mem_Write, Out_Mem_Read,
               Out_Jump_and_Link, Out_Immediate_Select, Out_Offset_Generate,
               Out_Branch, Out_Jump, Out_ALU_Opcode, Out_PC, Out_PC_next,
               Out_Data1, Out_Data2, Out_Immediate_value, Out_WriteAddress,
               Out_func3
    );

    modport slave (
        input  Write_Enable, Memory_Access, Mem_Write, Mem_Read, Jump_and_Link,
               Immediate_Select, Offset_Generate, Branch, Jump, ALU_Opcode,
               PC, PC_next, Data1, Data2, instruction, Immediate_value,
        output Out_Write_Enable, Out_Memory_Access, Out_Mem_Write, Out_Mem_Read,
               Out_Jump_and_Link, Out_Immediate_Select, Out_Offset_Generate,
               Out_Branch, Out_Jump, Out_ALU_Opcode, Out_PC, Out_PC_next,
               Out_Data1, Out_Data2, Out_Immediate_value, Out_WriteAddress,
               Out_func3
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_pipeline_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipeline_reg
// Description : ID/EX pipeline register of the RV32IM 5-stage core. Captures
//               decode control bits, PC / PC+4, operands and immediate on each
//               rising CLK edge and holds them for the execute stage. rd and
//               funct3 are sliced out of the instruction word at the same edge.
//               Ports:
//                 CLK   - rising-edge clock
//                 Reset - asynchronous active-high clear of every output
//                 bus   - id_ex_pipeline_reg_if.slave (decode in, Out_* out)
// Revision    : 1.0  initial release
// ============================================================================
module id_ex_pipeline_reg (
    input  wire logic            CLK,
    input  wire logic            Reset,
    id_ex_pipeline_reg_if.slave  bus
);

    logic        r_write_enable;
    logic        r_memory_access;
    logic        r_mem_write;
    logic        r_mem_read;
    logic        r_jump_and_link;
    logic        r_immediate_select;
    logic        r_offset_generate;
    logic        r_branch;
    logic        r_jump;
    logic [4:0]  r_alu_opcode;
    logic [31:0] r_pc;
    logic [31:0] r_pc_next;
    logic [31:0] r_data1;
    logic [31:0] r_data2;
    logic [31:0] r_immediate_value;
    logic [4:0]  r_write_address;
    logic [2:0]  r_func3;

    // Only rd and funct3 are kept; the remaining instruction bits are
    // deliberately dropped here.
    wire logic w_unused_instr_bits = ^{bus.instruction[31:15], bus.instruction[6:0]};

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_write_enable     <= 1'b0;
            r_memory_access    <= 1'b0;
            r_mem_write        <= 1'b0;
            r_mem_read         <= 1'b0;
            r_jump_and_link    <= 1'b0;
            r_immediate_select <= 1'b0;
            r_offset_generate  <= 1'b0;
            r_branch           <= 1'b0;
            r_jump             <= 1'b0;
            r_alu_opcode       <= 5'd0;
            r_pc               <= 32'd0;
            r_pc_next          <= 32'd0;
            r_data1            <= 32'd0;
            r_data2            <= 32'd0;
            r_immediate_value  <= 32'd0;
            r_write_address    <= 5'd0;
            r_func3            <= 3'd0;
        end else begin
            r_write_enable     <= bus.Write_Enable;
            r_memory_access    <= bus.Memory_Access;
            r_mem_write        <= bus.Mem_Write;
            r_mem_read         <= bus.Mem_Read;
            r_jump_and_link    <= bus.Jump_and_Link;
            r_immediate_select <= bus.Immediate_Select;
            r_offset_generate  <= bus.Offset_Generate;
            r_branch           <= bus.Branch;
            r_jump             <= bus.Jump;
            r_alu_opcode       <= bus.ALU_Opcode;
            r_pc               <= bus.PC;
            r_pc_next          <= bus.PC_next;
            r_data1            <= bus.Data1;
            r_data2            <= bus.Data2;
            r_immediate_value  <= bus.Immediate_value;
            r_write_address    <= bus.instruction[11:7];   // rd
            r_func3            <= bus.instruction[14:12];  // funct3
        end
    end

    assign bus.Out_Write_Enable     = r_write_enable;
    assign bus.Out_Memory_Access    = r_memory_access;
    assign bus.Out_Mem_Write        = r_mem_write;
    assign bus.Out_Mem_Read         = r_mem_read;
    assign bus.Out_Jump_and_Link    = r_jump_and_link;
    assign bus.Out_Immediate_Select = r_immediate_select;
    assign bus.Out_Offset_Generate  = r_offset_generate;
    assign bus.Out_Branch           = r_branch;
    assign bus.Out_Jump             = r_jump;
    assign bus.Out_ALU_Opcode       = r_alu_opcode;
    assign bus.Out_PC               = r_pc;
    assign bus.Out_PC_next          = r_pc_next;
    assign bus.Out_Data1            = r_data1;
    assign bus.Out_Data2            = r_data2;
    assign bus.Out_Immediate_value  = r_immediate_value;
    assign bus.Out_WriteAddress     = r_write_address;
    assign bus.Out_func3            = r_func3;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipeline_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_pipeline_reg
// Description : Self-checking bench for id_ex_pipeline_reg. A reference model
//               holds the expected output bundle: it becomes zero whenever
//               Reset is raised and takes a snapshot of the inputs at each
//               rising edge with Reset low.
// Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_pipeline_reg;

    localparam int c_W = 182;  // 9 ctrl + 5 alu + 5*32 + 5 rd + 3 funct3

    logic CLK;
    logic Reset;
    id_ex_pipeline_reg_if bus ();

    id_ex_pipeline_reg dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic [c_W-1:0] exp_q;

    task automatic check(input string tag, input logic [c_W-1:0] got,
                         input logic [c_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // What the execute stage should see after capturing the current inputs.
    function automatic logic [c_W-1:0] snapshot_inputs();
        logic [31:0] ins;
        ins = bus.instruction;
        return {bus.Write_Enable, bus.Memory_Access, bus.Mem_Write, bus.Mem_Read,
                bus.Jump_and_Link, bus.Immediate_Select, bus.Offset_Generate,
                bus.Branch, bus.Jump, bus.ALU_Opcode, bus.PC, bus.PC_next,
                bus.Data1, bus.Data2, bus.Immediate_value, ins[11:7], ins[14:12]};
    endfunction

    function automatic logic [c_W-1:0] observed();
        return {bus.Out_Write_Enable, bus.Out_Memory_Access, bus.Out_Mem_Write,
                bus.Out_Mem_Read, bus.Out_Jump_and_Link, bus.Out_Immediate_Select,
                bus.Out_Offset_Generate, bus.Out_Branch, bus.Out_Jump,
                bus.Out_ALU_Opcode, bus.Out_PC, bus.Out_PC_next, bus.Out_Data1,
                bus.Out_Data2, bus.Out_Immediate_value, bus.Out_WriteAddress,
                bus.Out_func3};
    endfunction

    task automatic drive(input logic [8:0] ctrl, input logic [4:0] alu,
                         input logic [31:0] pc, input logic [31:0] pcn,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] ins, input logic [31:0] imm);
        {bus.Write_Enable, bus.Memory_Access, bus.Mem_Write, bus.Mem_Read,
         bus.Jump_and_Link, bus.Immediate_Select, bus.Offset_Generate,
         bus.Branch, bus.Jump} = ctrl;
        bus.ALU_Opcode      = alu;
        bus.PC              = pc;
        bus.PC_next         = pcn;
        bus.Data1           = d1;
        bus.Data2           = d2;
        bus.instruction     = ins;
        bus.Immediate_value = imm;
    endtask

    task automatic drive_random();
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom;
        b = $urandom;
        drive(a[8:0], b[4:0], $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom);
    endtask

    task automatic set_reset(input logic v);
        Reset = v;
        if (v) exp_q = '0;
    endtask

    // One rising edge: the model loads unless Reset is high, then compare.
    task automatic tick(input string tag);
        @(posedge CLK);
        exp_q = Reset ? '0 : snapshot_inputs();
        #1;
        check(tag, observed(), exp_q);
    endtask

    initial begin
        logic [31:0] w;
        logic [c_W-1:0] held;
        exp_q = '0;

        // 1: reset with nonzero inputs
        set_reset(1'b1);
        drive(9'h1FF, 5'h1F, 32'h0, 32'h4, 32'hDEADBEEF, 32'hFEEDC0DE,
              32'hFFFFFFFF, 32'h12345678);
        #1;
        check("rst_immediate", observed(), '0);
        for (int i = 0; i < 3; i++) tick("rst_hold_edges");

        // 2: directed load
        @(negedge CLK);
        set_reset(1'b0);
        drive(9'b111_00_1110, 5'b01010, 32'h10000000, 32'h10000004,
              32'h12345678, 32'h87654321, 32'h00F00713, 32'h0000000F);
        #1;
        check("rst_release_no_load", observed(), '0);
        tick("directed_load");
        check("directed_rd", c_W'(bus.Out_WriteAddress), c_W'(5'h0E));
        check("directed_f3", c_W'(bus.Out_func3), c_W'(3'h0));
        check("directed_data1", c_W'(bus.Out_Data1), c_W'(32'h12345678));
        check("directed_alu", c_W'(bus.Out_ALU_Opcode), c_W'(5'b01010));

        // 3: mid-cycle input change holds outputs
        @(negedge CLK);
        held = exp_q;
        drive_random();
        #1;
        check("midcycle_hold", observed(), held);
        tick("midcycle_update");

        // 4: async assert / release between edges
        @(negedge CLK);
        drive(9'h1FF, 5'h11, 32'hA, 32'hB, 32'hC, 32'hD, 32'hFFFFFFFF, 32'hE);
        tick("nonzero_before_async");
        #2;
        set_reset(1'b1);
        #1;
        check("async_clear", observed(), '0);
        #2;
        set_reset(1'b0);
        #1;
        check("async_release_hold", observed(), '0);
        tick("load_after_release");

        // 5: instruction extremes and walking ones
        @(negedge CLK);
        drive(9'h0, 5'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0);
        tick("instr_all_ones");
        check("rd_1f", c_W'(bus.Out_WriteAddress), c_W'(5'h1F));
        check("f3_7", c_W'(bus.Out_func3), c_W'(3'h7));
        @(negedge CLK);
        drive(9'h1FF, 5'h1F, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000000, 32'h0);
        tick("instr_all_zeros");
        check("rd_00", c_W'(bus.Out_WriteAddress), c_W'(5'h00));
        check("f3_0", c_W'(bus.Out_func3), c_W'(3'h0));
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            w = 32'h1 << i;
            drive(9'h1 << (i % 9), 5'h1 << (i % 5), w, {w[0], w[31:1]},
                  {w[1:0], w[31:2]}, {w[2:0], w[31:3]}, w, {w[3:0], w[31:4]});
            tick("walking_ones");
        end

        // 6: 10 ns reset pulse spanning a rising edge
        @(negedge CLK);
        drive_random();
        tick("pulse_preload");
        @(negedge CLK);
        drive(9'h1FF, 5'h1F, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        set_reset(1'b1);
        #1;
        check("pulse_clear", observed(), '0);
        tick("pulse_no_load");
        @(negedge CLK);
        set_reset(1'b0);
        #1;
        check("pulse_after_release", observed(), '0);
        tick("pulse_first_load");

        // Randomized run with occasional async reset between edges
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            held = exp_q;
            drive_random();
            #1;
            check("rand_hold", observed(), held);
            set_reset($urandom_range(0, 9) == 0);
            #1;
            if (Reset) check("rand_async_clear", observed(), '0);
            tick("rand_edge");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
